// File: rtl/everloop_frame_buffer_if.sv
// -----------------------------------------------------------------------------
// everloop_frame_buffer_if
//
// Bus bundle between host logic, the everloop frame buffer and the downstream
// LED serializer.
//
//   wr_en     host write strobe, one write per cycle
//   wr_addr   LED index to write
//   wr_data   colour {R[23:16], G[15:8], B[7:0]}
//   commit    one-cycle pulse: back bank becomes front at next frame start
//   pix_data  GRB word {G,R,B} to the serializer
//   pix_valid pix_data valid
//   pix_ready serializer accepts the word when high together with pix_valid
//
// Modports:
//   master - host / serializer side (drives writes and pix_ready)
//   slave  - frame buffer side (drives the pixel stream)
// -----------------------------------------------------------------------------
interface everloop_frame_buffer_if #(
    parameter int ADDR_W = 6
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;
    logic              commit;
    logic [23:0]       pix_data;
    logic              pix_valid;
    logic              pix_ready;

    modport master (
        output wr_en, wr_addr, wr_data, commit, pix_ready,
        input  pix_data, pix_valid
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, commit, pix_ready,
        output pix_data, pix_valid
    );
endinterface

// File: rtl/everloop_frame_buffer.sv
// -----------------------------------------------------------------------------
// everloop_frame_buffer
//
// Double-buffered colour store for the everloop LED ring. The host writes RGB
// colours into the back bank and pulses commit; at the next refresh tick that
// starts a frame the banks swap. Every REFRESH_DIV cycles (when frame_en is
// high) the front bank is streamed LED 0 first as 24-bit GRB words over a
// valid/ready handshake. The idle time between frames is the strip latch gap.
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-low reset
//   bus         everloop_frame_buffer_if.slave (host writes + pixel stream)
//   frame_en    1 = periodic refresh enabled
//   busy        frame transmission in progress
//   frame_done  one-cycle pulse after the last LED word is accepted
//   overrun     sticky; a refresh tick arrived while a frame was in flight
// -----------------------------------------------------------------------------
module everloop_frame_buffer #(
    parameter int N_LEDS      = 35,
    parameter int ADDR_W      = 6,
    parameter int REFRESH_DIV = 1000000
) (
    input  logic                          clk,
    input  logic                          rst,
    everloop_frame_buffer_if.slave        bus,
    input  logic                          frame_en,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          overrun
);

    // Bank depth covers the whole index space so any index addresses an entry
    // directly; entries at or above N_LEDS are never written or read.
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_LEDS - 1);
    localparam logic [ADDR_W:0]   N_LEDS_X = (ADDR_W + 1)'(N_LEDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]        state_q,     state_d;
    logic [ADDR_W-1:0] idx_q,       idx_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              front_sel_q, front_sel_d;
    logic              pend_q,      pend_d;
    logic              overrun_q,   overrun_d;
    logic [23:0]       pix_data_q,  pix_data_d;
    logic              pix_valid_q, pix_valid_d;

    logic [23:0] bank0_q [DEPTH];
    logic [23:0] bank1_q [DEPTH];

    logic        tick;
    logic        wr_in_range;
    logic [23:0] front_word;

    assign tick        = (cnt_q == CNT_MAX);
    assign wr_in_range = ({1'b0, bus.wr_addr} < N_LEDS_X);
    assign front_word  = front_sel_q ? bank1_q[idx_q] : bank0_q[idx_q];

    // -------------------------------------------------------------------------
    // Colour RAM: host writes always land in the back bank, so the bank being
    // streamed is never modified mid-frame.
    // -------------------------------------------------------------------------
    // NOTE: the RAM has no reset branch; resetting storage would prevent RAM
    // inference and its contents are defined only by host writes anyway.
    always_ff @(posedge clk) begin
        if (bus.wr_en && wr_in_range) begin
            if (front_sel_q) begin
                bank0_q[bus.wr_addr] <= bus.wr_data;
            end else begin
                bank1_q[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned below gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = tick ? '0 : cnt_q + 1'b1;
        front_sel_d = front_sel_q;
        pend_d      = pend_q | bus.commit;
        overrun_d   = overrun_q;
        pix_data_d  = pix_data_q;
        pix_valid_d = pix_valid_q;

        // A tick is only consumed from IDLE; anywhere else it is dropped.
        if (tick && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (tick && frame_en) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                    // Swap at frame start; a commit in this very cycle is kept
                    // pending for the following frame.
                    if (pend_q) begin
                        front_sel_d = ~front_sel_q;
                        pend_d      = bus.commit;
                    end
                end
            end
            S_LOAD: begin
                // Registered read of front[idx], reordered RGB -> GRB.
                pix_data_d  = {front_word[15:8], front_word[23:16], front_word[7:0]};
                pix_valid_d = 1'b1;
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (bus.pix_ready) begin
                    pix_valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            front_sel_q <= 1'b0;
            pend_q      <= 1'b0;
            overrun_q   <= 1'b0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            front_sel_q <= front_sel_d;
            pend_q      <= pend_d;
            overrun_q   <= overrun_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all decoded from registers)
    // -------------------------------------------------------------------------
    assign bus.pix_data  = pix_data_q;
    assign bus.pix_valid = pix_valid_q;
    assign busy          = (state_q == S_LOAD) || (state_q == S_SEND);
    assign frame_done    = (state_q == S_DONE);
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_everloop_frame_buffer.sv
// -----------------------------------------------------------------------------
// tb_everloop_frame_buffer
//
// Self-checking bench for everloop_frame_buffer with N_LEDS=4, REFRESH_DIV=200.
// A table of {address, RGB colour, expected GRB word} records drives the host
// writes; expected words are pushed to a scoreboard queue before each frame and
// a monitor pops and compares them on every accepted handshake. Hand-written
// sequences cover back-pressure, mid-frame commit, overrun, disabled refresh
// with an out-of-range write, and reset in the middle of a frame.
// -----------------------------------------------------------------------------
module tb_everloop_frame_buffer;

    localparam int N_LEDS      = 4;
    localparam int ADDR_W      = 6;
    localparam int REFRESH_DIV = 200;
    // Release -> first tick after REFRESH_DIV edges, then one LOAD cycle.
    localparam int START_LAT   = REFRESH_DIV + 1;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic frame_en = 1'b0;
    logic busy;
    logic frame_done;
    logic overrun;

    everloop_frame_buffer_if #(.ADDR_W(ADDR_W)) bus ();

    everloop_frame_buffer #(
        .N_LEDS      (N_LEDS),
        .ADDR_W      (ADDR_W),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .frame_en   (frame_en),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [23:0]       rgb;
        logic [23:0]       grb;
    } vec_t;

    vec_t        vecs [N_LEDS];
    logic [23:0] orig [N_LEDS];
    logic [23:0] upd  [N_LEDS];
    logic [23:0] exp_q [$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int acc_cnt  = 0;
    int rel_cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Scoreboard monitor: sampled just after the falling edge, i.e. the values
    // the DUT will see at the next rising edge.
    always begin
        @(negedge clk);
        #1;
        if (rst && bus.pix_valid && bus.pix_ready) begin
            if (exp_q.size() == 0) begin
                fail_now("pix_word: word accepted with empty scoreboard");
            end else begin
                check("pix_word", {8'h0, bus.pix_data}, {8'h0, exp_q.pop_front()});
            end
            acc_cnt++;
        end
    end

    task automatic write_led(input logic [ADDR_W-1:0] a, input logic [23:0] d);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic pulse_commit();
        @(negedge clk);
        bus.commit = 1'b1;
        @(negedge clk);
        bus.commit = 1'b0;
    endtask

    task automatic push_frame(input logic [23:0] f [N_LEDS]);
        for (int i = 0; i < N_LEDS; i++) exp_q.push_back(f[i]);
    endtask

    task automatic wait_valid(input string name, output int start);
        start = -1;
        for (int i = 0; i < REFRESH_DIV + 50; i++) begin
            @(negedge clk);
            if (bus.pix_valid) begin
                start = cyc;
                break;
            end
        end
        if (start < 0) fail_now({name, ": no pix_valid within budget"});
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        if (!seen) begin
            fail_now({name, ": no frame_done within budget"});
        end else begin
            @(negedge clk);
            check({name, "_done_width"}, {31'h0, frame_done}, 32'h0);
            check({name, "_busy_after"}, {31'h0, busy}, 32'h0);
            check({name, "_words_left"}, exp_q.size(), 32'h0);
        end
    endtask

    initial begin
        int t0;
        int t6;
        int t7;
        int acc_base;
        int valid_seen;
        int busy_seen;
        bit found;

        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.commit    = 1'b0;
        bus.pix_ready = 1'b1;

        vecs[0] = '{6'd0, 24'hFF0000, 24'h00FF00};
        vecs[1] = '{6'd1, 24'h00FF00, 24'hFF0000};
        vecs[2] = '{6'd2, 24'h0000FF, 24'h0000FF};
        vecs[3] = '{6'd3, 24'h102030, 24'h201030};
        for (int i = 0; i < N_LEDS; i++) begin
            orig[i] = vecs[i].grb;
            upd[i]  = vecs[i].grb;
        end
        upd[0] = 24'h0B0A0C;

        // ---------------- reset state ----------------
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pix_valid",  {31'h0, bus.pix_valid}, 32'h0);
        check("rst_pix_data",   {8'h0, bus.pix_data},   32'h0);
        check("rst_busy",       {31'h0, busy},          32'h0);
        check("rst_frame_done", {31'h0, frame_done},    32'h0);
        check("rst_overrun",    {31'h0, overrun},       32'h0);
        rst     = 1'b1;
        rel_cyc = cyc;

        // ---------------- frame 1: table-driven load ----------------
        frame_en = 1'b1;
        for (int i = 0; i < N_LEDS; i++) write_led(vecs[i].addr, vecs[i].rgb);
        pulse_commit();
        push_frame(orig);
        wait_valid("frame1_start", t0);
        check("frame1_latency", t0 - rel_cyc, START_LAT);
        wait_done("frame1");

        // ---------------- frame 2: back-pressure on word 1 ----------------
        push_frame(orig);
        wait_valid("frame2_start", t0);
        @(negedge clk);
        check("bp_bubble", {31'h0, bus.pix_valid}, 32'h0);
        bus.pix_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", {31'h0, bus.pix_valid}, 32'h1);
            check("bp_data",  {8'h0, bus.pix_data},   {8'h0, orig[1]});
        end
        bus.pix_ready = 1'b1;
        wait_done("frame2");

        // ---------------- frames 3-5: commit mid-frame ----------------
        push_frame(orig);
        wait_valid("frame3_start", t0);
        write_led(6'd0, 24'h0A0B0C);
        check("commit_midframe_busy", {31'h0, busy}, 32'h1);
        pulse_commit();
        wait_done("frame3");
        for (int i = 1; i < N_LEDS; i++) write_led(vecs[i].addr, vecs[i].rgb);
        push_frame(upd);
        wait_valid("frame4_start", t0);
        wait_done("frame4");
        push_frame(upd);
        wait_valid("frame5_start", t0);
        wait_done("frame5");
        check("no_overrun_yet", {31'h0, overrun}, 32'h0);

        // ---------------- frames 6-7: overrun ----------------
        bus.pix_ready = 1'b0;
        push_frame(upd);
        wait_valid("frame6_start", t6);
        repeat (REFRESH_DIV + 10) @(negedge clk);
        check("ovr_flag",  {31'h0, overrun},       32'h1);
        check("ovr_busy",  {31'h0, busy},          32'h1);
        check("ovr_valid", {31'h0, bus.pix_valid}, 32'h1);
        check("ovr_data",  {8'h0, bus.pix_data},   {8'h0, upd[0]});
        bus.pix_ready = 1'b1;
        wait_done("frame6");
        check("ovr_sticky", {31'h0, overrun}, 32'h1);
        push_frame(upd);
        wait_valid("frame7_start", t7);
        check("frame7_period", t7 - t6, 2 * REFRESH_DIV);
        wait_done("frame7");

        // ---------------- disabled refresh + out-of-range write ----------------
        frame_en = 1'b0;
        write_led(6'd7, 24'hFFFFFF);
        pulse_commit();
        valid_seen = 0;
        busy_seen  = 0;
        for (int i = 0; i < 2 * REFRESH_DIV + 50; i++) begin
            @(negedge clk);
            if (bus.pix_valid) valid_seen++;
            if (busy) busy_seen++;
        end
        check("disabled_valid", valid_seen, 32'h0);
        check("disabled_busy",  busy_seen,  32'h0);
        frame_en = 1'b1;
        push_frame(orig);
        wait_valid("frame8_start", t0);
        wait_done("frame8");

        // ---------------- reset during word 2 ----------------
        push_frame(orig);
        acc_base = acc_cnt;
        wait_valid("frame9_start", t0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (acc_cnt == acc_base + 2 && bus.pix_valid) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) fail_now("midrst: word 2 never presented");
        rst = 1'b0;
        #1;
        check("midrst_pix_valid",  {31'h0, bus.pix_valid}, 32'h0);
        check("midrst_busy",       {31'h0, busy},          32'h0);
        check("midrst_frame_done", {31'h0, frame_done},    32'h0);
        check("midrst_pix_data",   {8'h0, bus.pix_data},   32'h0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("midrst_overrun", {31'h0, overrun}, 32'h0);
        rst     = 1'b1;
        rel_cyc = cyc;
        // Front select returns to bank 0, which holds the updated colours.
        push_frame(upd);
        wait_valid("postrst_start", t0);
        check("postrst_latency", t0 - rel_cyc, START_LAT);
        wait_done("postrst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/everloop_frame_buffer.md
Name: everloop_frame_buffer

Overview:
- Upstream pixel source for the everloop serial LED driver: holds one RGB colour per ring LED in a double-buffered RAM.
- Host logic writes the back bank and commits it; the block periodically streams the front bank, LED 0 first, as 24-bit GRB words over a valid/ready handshake.
- The downstream serializer converts each word to the led_ctl waveform.
- The idle gap between frames provides the strip's latch/reset time.

Parameters:
- N_LEDS, 35, number of LEDs in the ring (1..64)
- ADDR_W, 6, width of LED index
- REFRESH_DIV, 1000000, clk cycles between frame starts (20 ms at 50 MHz); must exceed the frame transmit time plus latch gap

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-low reset
- wr_en  in  1  host write strobe, one write per cycle
- wr_addr  in  ADDR_W  LED index to write
- wr_data  in  24  colour {R[23:16], G[15:8], B[7:0]}
- commit  in  1  one-cycle pulse: back bank becomes front at next frame start
- frame_en  in  1  1 = periodic refresh enabled
- pix_data  out  24  GRB word {G,R,B} to serializer
- pix_valid  out  1  pix_data valid
- pix_ready  in  1  serializer accepts word when high with pix_valid
- busy  out  1  frame transmission in progress
- frame_done  out  1  one-cycle pulse after last LED word accepted
- overrun  out  1  sticky; refresh tick arrived while busy

Behaviour:
- Reset (rst=0, asynchronous):
  - pix_valid=0, pix_data=0, busy=0, frame_done=0, overrun=0.
  - Front bank select=0, commit_pending=0, refresh counter=0, FSM=IDLE.
  - RAM contents are not reset.
- Host write: wr_en=1 writes wr_data into the back bank at wr_addr on that clk edge.
  - wr_addr >= N_LEDS is ignored.
  - Writes never touch the front bank, so a frame in flight is never torn.
- commit sets commit_pending. commit while commit_pending is already set has no further effect.
- Refresh counter:
  - Free-runs 0..REFRESH_DIV-1 and wraps.
  - tick = counter==REFRESH_DIV-1.
  - The counter runs regardless of frame_en.
- FSM states: IDLE, LOAD, SEND, DONE.
  - IDLE -> LOAD on tick & frame_en.
    - On this transition, if commit_pending: swap banks and clear commit_pending, in the same cycle.
    - If commit arrives in that same cycle, it sets commit_pending for the next frame.
    - idx=0, busy=1.
  - LOAD: registered RAM read of front[idx]; one cycle latency. Next cycle: pix_data={G,R,B}, pix_valid=1, go to SEND.
  - SEND: pix_data and pix_valid stay stable until pix_ready=1.
    - On accept with idx<N_LEDS-1: idx++, pix_valid=0, return to LOAD.
    - This gives one bubble cycle per word, acceptable since the serializer needs ~30 us per LED.
    - On accept with idx==N_LEDS-1: pix_valid=0, go to DONE.
  - DONE: frame_done=1 for exactly one cycle, busy=0, go to IDLE.
- tick while FSM != IDLE: tick is dropped and overrun=1 (sticky until reset). The current frame is not disturbed.
- frame_en deasserted mid-frame: the current frame completes; no new frame starts.
- Host writes to the back bank mid-frame are allowed.
- Word order: idx 0 first through N_LEDS-1. Exactly N_LEDS words per frame.
- Reset mid-frame: outputs return to reset values immediately; the partial frame is abandoned and the serializer's latch gap handles the strip.

Test Plan:
- N_LEDS=4, REFRESH_DIV=200, pix_ready tied 1.
  - Write back bank LEDs 0..3 = 24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h102030; commit; frame_en=1.
  - Required: first frame after cycle 199 emits 24'h00FF00, 24'hFF0000, 24'h0000FF, 24'h201030.
  - Then frame_done pulses once and busy=0.
- Back-pressure: pix_ready held low 10 cycles on word 1.
  - Required: pix_valid=1 and pix_data=24'hFF0000 stable for all 10 cycles; no word skipped or duplicated.
- Write LED0=24'h0A0B0C and pulse commit mid-frame.
  - Required: the current frame still shows the old data.
  - The next frame shows LED0 as 24'h0B0A0C; a third frame without commit repeats it.
- Hold pix_ready=0 past the next tick.
  - Required: overrun=1 and stays 1.
  - After release the frame finishes normally with 4 words, and the next frame starts on the following tick.
- frame_en=0, then write wr_addr=7 with 24'hFFFFFF and commit.
  - Required: no pix_valid ever; after frame_en=1, LEDs 0..3 are unchanged by the out-of-range write.
- Assert rst=0 during word 2.
  - Required: pix_valid, busy, frame_done go to 0 asynchronously.
  - After release, the first frame starts at counter wrap (cycle 199).
